// File: rtl/psum_gbf_drain_if.sv
// psum_gbf_drain_if: psum GBF write / BRAM read bus between the drain unit (master) and the global buffer (slave)
interface psum_gbf_drain_if #(
    parameter int GBF_DATA_BITWIDTH  = 512,
    parameter int BRAM_ADDR_BITWIDTH = 10
);
    logic [GBF_DATA_BITWIDTH-1:0]  out_data;
    logic                          psum_write_en;
    logic                          psum_write_ready;
    logic                          psum_read_en;
    logic [GBF_DATA_BITWIDTH-1:0]  psum_read_data;
    logic [BRAM_ADDR_BITWIDTH-1:0] psum_BRAM_addr;
    modport master (
        output out_data, psum_write_en, psum_read_en, psum_BRAM_addr,
        input  psum_write_ready, psum_read_data
    );
    modport slave (
        input  out_data, psum_write_en, psum_read_en, psum_BRAM_addr,
        output psum_write_ready, psum_read_data
    );
endinterface

// File: rtl/psum_gbf_drain.sv
// psum_gbf_drain: serialises PSUM RF entries into GBF beats over a circular BRAM region; PSUM_ACC_EN adds read-modify-write accumulation
module psum_gbf_drain #(
    parameter int ROW                   = 16,
    parameter int COL                   = 16,
    parameter int DATA_BITWIDTH         = 16,
    parameter int GBF_DATA_BITWIDTH     = 512,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int BRAM_ADDR_BITWIDTH    = 10
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [BRAM_ADDR_BITWIDTH-1:0]        cfg_base_addr,
    input  logic [BRAM_ADDR_BITWIDTH-1:0]        cfg_psum_num,
    input  logic [PSUM_RF_ADDR_BITWIDTH-1:0]     cfg_rf_last,
    input  logic                                 acc_mode,
    input  logic                                 pe_psum_finish,
    input  logic                                 conv_finish,
    input  logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_out,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
    output logic                                 su_add_finish,
    psum_gbf_drain_if.master                     gbf
);
    localparam int TOTAL = DATA_BITWIDTH * ROW * COL;
    localparam int G     = GBF_DATA_BITWIDTH;
    localparam int BEATS = TOTAL / G;
    localparam int LANES = G / DATA_BITWIDTH;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(BEATS - 1);
    if (TOTAL % G != 0 || G % DATA_BITWIDTH != 0) begin : g_bad_cfg
        $error("psum_gbf_drain: ROW*COL*DATA_BITWIDTH must be a multiple of GBF_DATA_BITWIDTH");
    end
    typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;
    state_t                        state;
    logic [BW-1:0]                 b;
    logic [BRAM_ADDR_BITWIDTH-1:0] off;
    logic [BRAM_ADDR_BITWIDTH-1:0] off_last;
    logic                          conv_seen;
    logic                          write_en;
    logic                          read_en;
    logic                          acc;
    logic                          acc_q;
    logic                          accept;
    logic                          pass_done;
    logic [G-1:0]                  slice;
    assign slice     = psum_out[G*(BEATS-1-int'(b)) +: G];
    assign off_last  = cfg_psum_num == '0 ? '0 : cfg_psum_num - 1'b1;
    assign accept    = write_en && gbf.psum_write_ready;
    assign pass_done = b == B_LAST && psum_rf_addr == cfg_rf_last;
    assign gbf.psum_write_en  = write_en;
    assign gbf.psum_BRAM_addr = cfg_base_addr + off;
`ifdef PSUM_ACC_EN
    logic [G-1:0] sum;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sum[i*DATA_BITWIDTH +: DATA_BITWIDTH] = slice[i*DATA_BITWIDTH +: DATA_BITWIDTH]
                                                     + gbf.psum_read_data[i*DATA_BITWIDTH +: DATA_BITWIDTH];
    end
    assign acc              = acc_mode;
    assign gbf.out_data     = acc_q ? sum : slice;
    assign gbf.psum_read_en = read_en;
`else
    logic unused_in;
    assign unused_in        = ^{acc_mode, gbf.psum_read_data};
    assign acc              = 1'b0;
    assign gbf.out_data     = slice;
    assign gbf.psum_read_en = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            b             <= '0;
            off           <= '0;
            psum_rf_addr  <= '0;
            conv_seen     <= 1'b0;
            write_en      <= 1'b0;
            read_en       <= 1'b0;
            acc_q         <= 1'b0;
            su_add_finish <= 1'b1;
        end else begin
            conv_seen <= conv_seen || conv_finish;
            case (state)
                IDLE: begin
                    if (pe_psum_finish) begin
                        state         <= DRAIN;
                        acc_q         <= acc;
                        write_en      <= !acc;
                        read_en       <= acc;
                        su_add_finish <= 1'b0;
                    end else if (conv_finish || conv_seen) begin
                        state         <= FINISH;
                        su_add_finish <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (read_en) begin
                        read_en  <= 1'b0;
                        write_en <= 1'b1;
                    end else if (accept) begin
                        off      <= off == off_last ? '0 : off + 1'b1;
                        b        <= b == B_LAST ? '0 : b + 1'b1;
                        write_en <= !pass_done && !acc_q;
                        read_en  <= !pass_done && acc_q;
                        if (b == B_LAST)
                            psum_rf_addr <= pass_done ? '0 : psum_rf_addr + 1'b1;
                        if (pass_done) begin
                            state         <= (conv_seen || conv_finish) ? FINISH : IDLE;
                            su_add_finish <= !(conv_seen || conv_finish);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/psum_gbf_drain.md
# psum_gbf_drain

Parametrised drain unit between the PE array partial-sum register files and the psum global buffer (BRAM). It serialises every selected PSUM RF entry of the ROW×COL array into GBF_DATA_BITWIDTH-wide beats, addresses the psum BRAM as a circular region, and honours GBF back-pressure. Optionally it read-modify-writes existing BRAM contents so that partial sums over irrelevant operands (C, FX, FY) accumulate across passes.

## Interface
- ROW, 16, PE array rows
- COL, 16, PE array columns
- DATA_BITWIDTH, 16, psum element width
- GBF_DATA_BITWIDTH, 512, beat width; ROW·COL·DATA_BITWIDTH must be an integer multiple of it (elaboration error otherwise)
- PSUM_RF_ADDR_BITWIDTH, 2, PSUM RF address width
- BRAM_ADDR_BITWIDTH, 10, psum BRAM address width
- Derived: BEATS = ROW·COL·DATA_BITWIDTH/GBF_DATA_BITWIDTH; LANES = GBF_DATA_BITWIDTH/DATA_BITWIDTH

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cfg_base_addr  in  BRAM_ADDR_BITWIDTH  first BRAM address of the region
- cfg_psum_num  in  BRAM_ADDR_BITWIDTH  region length in beats; 0 is treated as 1
- cfg_rf_last  in  PSUM_RF_ADDR_BITWIDTH  last RF entry drained per pass
- acc_mode  in  1  1 = accumulate into BRAM (PSUM_ACC_EN only)
- pe_psum_finish  in  1  start pulse for one drain pass
- conv_finish  in  1  layer done; sticky once sampled
- psum_out  in  DATA_BITWIDTH·ROW·COL  RF contents at psum_rf_addr (async RF read)
- psum_rf_addr  out  PSUM_RF_ADDR_BITWIDTH  RF entry being drained
- su_add_finish  out  1  high only in IDLE
- out_data  out  GBF_DATA_BITWIDTH  write data
- psum_write_en  out  1  write request
- psum_write_ready  in  1  GBF accepts the write when both it and psum_write_en are high
- psum_read_en  out  1  BRAM read request (accumulate mode)
- psum_read_data  in  GBF_DATA_BITWIDTH  BRAM read data, valid one cycle after psum_read_en and held until the next read
- psum_BRAM_addr  out  BRAM_ADDR_BITWIDTH  cfg_base_addr + offset, truncated

## Operation
- States: IDLE, DRAIN (phases RD/WR), FINISH.
- IDLE → DRAIN on pe_psum_finish. IDLE → FINISH when conv_finish is high and no start is pending. pe_psum_finish in DRAIN or FINISH is ignored.
- Beat counter b runs 0..BEATS-1. out_data = psum_out slice b, MSB-first: beat 0 is bits [top : top-GBF_DATA_BITWIDTH+1]. The slice is combinational from psum_out.
- An accepted write advances b. At b = BEATS-1, b wraps to 0 and psum_rf_addr increments.
- If psum_rf_addr = cfg_rf_last at the last beat: psum_rf_addr returns to 0 and the state goes to IDLE, or to FINISH if conv_finish was seen during the pass.
- Offset counter advances on each accepted write and wraps to 0 after cfg_psum_num writes. It persists across passes and is cleared only by reset.
- Simultaneous pe_psum_finish and conv_finish in IDLE: the pass runs to completion, then FINISH.
- FINISH is held until reset. In FINISH: su_add_finish=0 and no reads or writes are issued.
- Reset value of every output: psum_rf_addr 0, psum_write_en 0, psum_read_en 0, su_add_finish 1 (IDLE), psum_BRAM_addr = cfg_base_addr (offset 0), out_data = slice 0 of psum_out. Internal counters and the sticky conv_finish flag clear.
- Reset mid-pass aborts the pass at the next edge; no partial-state recovery.

## Timing
- Start sampled at edge t: psum_write_en=1 from cycle t+1, carrying beat 0 at the current address.
- With psum_write_ready held high, one beat per cycle. A pass of N=(cfg_rf_last+1)·BEATS beats occupies cycles t+1..t+N; IDLE and su_add_finish=1 at t+N+1.
- With psum_write_ready low: out_data, psum_BRAM_addr and psum_rf_addr are held stable and psum_write_en stays high.
- psum_rf_addr changes on the edge that accepts the last beat of an entry. psum_out must reflect the new address in the following cycle.

## Configuration
- PSUM_ACC_EN defined, acc_mode=1: each beat takes an RD cycle (psum_read_en=1, address shown) followed by WR cycle(s) with psum_write_en=1.
  - out_data = lane-wise (slice + psum_read_data), each lane modulo 2^DATA_BITWIDTH.
  - Same address in both phases; minimum 2 cycles per beat; back-pressure only stalls WR.
- PSUM_ACC_EN undefined: acc_mode and psum_read_data are ignored, psum_read_en is tied 0, and behaviour is the write-only drain above.

## Test plan
- Defaults (BEATS 8, LANES 32), base 0, psum_num 64, rf_last 3, ready=1, start pulse → 32 consecutive writes at addresses 0..31; psum_rf_addr steps every 8 cycles; su_add_finish high at cycle 33.
- Same setup, ready low for 5 cycles during beat 3 → beat 3 data/address held, pass completes in 37 cycles, no duplicate or lost beats.
- psum_num 40, base 0x100, two passes → addresses 0x100..0x11F, then 0x120..0x127 followed by 0x100..0x117.
- conv_finish pulsed mid-pass → all 32 writes complete, then FINISH; a later start produces no writes and su_add_finish stays 0 until reset_n low.
- reset_n low at beat 10 → next cycle psum_write_en 0, psum_rf_addr 0, su_add_finish 1, address back to base.
- PSUM_ACC_EN, acc_mode=1, every psum lane 0xFFFF, read lanes 0x0001 → every written lane 0x0000; pass takes 64 cycles with read_en/write_en alternating.
